// File: rtl/logic_op_pkg.sv
// Shared opcode constants, FSM state type and width helper
// for the logic-op arbiter.
package logic_op_pkg;

   localparam logic [1:0] OP_XOR  = 2'd0;
   localparam logic [1:0] OP_XNOR = 2'd1;
   localparam logic [1:0] OP_NAND = 2'd2;
   localparam logic [1:0] OP_NOR  = 2'd3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Shared bitwise logic unit: XOR, XNOR, NAND, NOR.
// Purely combinational.
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit among NREQ
// requesters, with a single registered response slot.
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   localparam int IDW  = (clog2(NREQ) > 1) ? clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  busy
);

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_found;
   logic             slot_free;
   logic             accept;
   int               cand;
   int               sel;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] unit_y;

   // search starts at ptr so the last winner has lowest priority
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(cand);
         end
      end
   end

   assign slot_free = (state == ST_EMPTY) || rsp_ready;
   assign accept    = slot_free && gnt_found;
   assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

   assign sel    = int'(gnt_idx);
   assign sel_op = req_op[2*sel +: 2];
   assign sel_a  = req_a[WIDTH*sel +: WIDTH];
   assign sel_b  = req_b[WIDTH*sel +: WIDTH];

   logic_op_unit #(
      .WIDTH(WIDTH)
   ) u_unit (
      .op(sel_op),
      .a (sel_a),
      .b (sel_b),
      .y (unit_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         ptr    <= '0;
         rsp_y  <= '0;
         rsp_id <= '0;
      end else if (accept) begin
         state  <= ST_FULL;
         rsp_y  <= unit_y;
         rsp_id <= gnt_idx;
         ptr    <= (gnt_idx == IDW'(NREQ-1)) ? '0
                                              : gnt_idx + 1'b1;
      end else if (state == ST_FULL && rsp_ready) begin
         state <= ST_EMPTY;
      end
   end

   assign rsp_valid = (state == ST_FULL);
   assign busy      = rsp_valid;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: constant vectors, directed
// corner sequences and random traffic against a queue-free model.
module tb_logic_op_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] valid;
   logic [N-1:0] ready;
   logic [2*N-1:0] op;
   logic [W*N-1:0] a;
   logic [W*N-1:0] b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [W-1:0] rsp_y;
   logic         busy;

   int checks;
   int errors;

   bit       m_valid;
   bit [7:0] m_y;
   int       m_id;
   int       m_ptr;
   int       last_g;

   logic_op_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(valid),
      .req_ready(ready),
      .req_op   (op),
      .req_a    (a),
      .req_b    (b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_y    (rsp_y),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit [7:0] fref(input int o, input bit [7:0] x,
                                     input bit [7:0] y);
      case (o)
         0: return x ^ y;
         1: return ~(x ^ y);
         2: return ~(x & y);
         default: return ~(x | y);
      endcase
   endfunction

   function automatic int model_grant();
      if (m_valid && !rsp_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input int o, input bit [7:0] x,
                          input bit [7:0] y);
      valid[i]       = 1'b1;
      op[2*i +: 2]   = 2'(o);
      a[W*i +: W]    = x;
      b[W*i +: W]    = y;
   endtask

   // inputs change at posedge+1; checks at negedge; model steps at posedge
   task automatic cycle();
      int g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      g = model_grant();
      exp_rdy = (g < 0) ? '0 : N'(1) << g;
      chk("req_ready", 64'(ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_valid));
      if (m_valid) begin
         chk("rsp_y", 64'(rsp_y), 64'(m_y));
         chk("rsp_id", 64'(rsp_id), 64'(m_id));
      end
      @(posedge clk);
      if (g >= 0) begin
         m_y     = fref(int'(op[2*g +: 2]), a[W*g +: W], b[W*g +: W]);
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % N;
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
      last_g = g;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = '0;
      m_valid = 0; m_y = 0; m_id = 0; m_ptr = 0;
      #1;
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_y", 64'(rsp_y), 64'd0);
      chk("rst_id", 64'(rsp_id), 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int       id;
      int       o;
      bit [7:0] x;
      bit [7:0] y;
      bit [7:0] exp_y;
   } vec_t;

   vec_t vecs[5];
   int   exp_ids[6];
   bit [7:0] held_y;
   logic [1:0] held_id;

   initial begin
      checks = 0; errors = 0;
      valid = '0; op = '0; a = '0; b = '0;
      rsp_ready = 1'b1;
      last_g = -1;

      vecs[0] = '{0, 0, 8'hF0, 8'hAA, 8'h5A};
      vecs[1] = '{1, 0, 8'hC3, 8'h0F, 8'hCC};
      vecs[2] = '{1, 1, 8'hC3, 8'h0F, 8'h33};
      vecs[3] = '{1, 2, 8'hC3, 8'h0F, 8'hFC};
      vecs[4] = '{1, 3, 8'hC3, 8'h0F, 8'h30};

      do_reset();

      // constant vectors; requester 1 runs back-to-back
      for (int v = 0; v < 5; v++) begin
         valid = '0;
         set_req(vecs[v].id, vecs[v].o, vecs[v].x, vecs[v].y);
         cycle();
         chk("vec_valid", 64'(rsp_valid), 64'd1);
         chk("vec_y", 64'(rsp_y), 64'(vecs[v].exp_y));
         chk("vec_id", 64'(rsp_id), 64'(vecs[v].id));
      end
      valid = '0;
      cycle();
      chk("drain_valid", 64'(rsp_valid), 64'd0);

      // all requesters continuously valid from ptr 0
      do_reset();
      exp_ids = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < N; i++) set_req(i, i, 8'(8'h11 * (i + 1)), 8'h5C);
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("rr_id", 64'(rsp_id), 64'(exp_ids[k]));
      end

      // backpressure: held result stays stable, no grants
      rsp_ready = 1'b0;
      held_y = rsp_y;
      held_id = rsp_id;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("bp_y", 64'(rsp_y), 64'(held_y));
         chk("bp_id", 64'(rsp_id), 64'(held_id));
         chk("bp_valid", 64'(rsp_valid), 64'd1);
      end
      rsp_ready = 1'b1;
      cycle();
      chk("bp_refill_id", 64'(rsp_id), 64'd2);
      chk("bp_refill_valid", 64'(rsp_valid), 64'd1);

      // wrap: after requester 3, requester 0 wins over 3
      do_reset();
      set_req(3, 2, 8'h0F, 8'hFF);
      cycle();
      chk("wrap_id3", 64'(rsp_id), 64'd3);
      set_req(0, 3, 8'h01, 8'h02);
      cycle();
      chk("wrap_id0", 64'(rsp_id), 64'd0);
      chk("wrap_y0", 64'(rsp_y), 64'hFC);
      valid[0] = 1'b0;
      cycle();
      chk("wrap_id3b", 64'(rsp_id), 64'd3);
      valid = '0;
      cycle();

      // asynchronous reset while FULL and stalled
      set_req(3, 0, 8'hAA, 8'h55);
      cycle();
      rsp_ready = 1'b0;
      valid = '0;
      cycle();
      chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
      do_reset();
      rsp_ready = 1'b1;
      set_req(2, 1, 8'h3C, 8'h3C);
      set_req(3, 0, 8'h3C, 8'h00);
      cycle();
      chk("post_rst_id", 64'(rsp_id), 64'd2);
      chk("post_rst_y", 64'(rsp_y), 64'hFF);
      valid = '0;
      cycle();
      cycle();

      // random traffic; requests held until accepted
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_g == i) valid[i] = 1'b0;
            if (!valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, int'($urandom_range(0, 3)),
                       8'($urandom), 8'($urandom));
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic unit (XOR, XNOR, NAND, NOR) among NREQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one requester per cycle, computes through the shared unit, and returns the result with the winner's ID on a single registered valid/ready response channel. It sits between the requesting datapaths and the shared gate-level logic unit.

## Interface
Parameters:
- WIDTH, 8, operand/result width (1..64)
- NREQ, 4, number of requesters (2..16)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i = requester i has a request
- req_ready  out  NREQ  one-hot (or zero) grant; acceptance = valid & ready
- req_op  in  2*NREQ  opcode for requester i at [2i+1:2i]
- req_a  in  WIDTH*NREQ  operand A for requester i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*NREQ  operand B, same packing
- rsp_valid  out  1  result held in the output register
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  max(1,clog2(NREQ))  index of the requester that owns rsp_y
- rsp_y  out  WIDTH  result
- busy  out  1  equals rsp_valid

## Operation
- Opcodes: 0 = XOR (a^b), 1 = XNOR ~(a^b), 2 = NAND ~(a&b), 3 = NOR ~(a|b). Bitwise; result width = WIDTH; no carries.
- FSM has 2 states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- Slot is free when state is EMPTY, or when FULL and rsp_ready=1 in the same cycle (drain and refill in one cycle).
- Grant rule:
  - When the slot is free, req_ready is asserted to the first i with req_valid[i]=1, searching from ptr, ptr+1, … modulo NREQ.
  - Otherwise req_ready is all 0.
- req_ready depends combinationally on req_valid, ptr, state and rsp_ready. No other path is combinational.
- On acceptance of requester g:
  - rsp_y <= f(op_g, a_g, b_g); rsp_id <= g; state -> FULL.
  - ptr <= (g+1) mod NREQ, wrapping NREQ-1 -> 0.
- FULL, rsp_ready=1, no acceptance: state -> EMPTY. rsp_y and rsp_id keep their last values.
- FULL, rsp_ready=0: rsp_valid, rsp_y and rsp_id stay stable, and every req_ready is 0.
- No requests: ptr unchanged.
- Fairness: a continuously asserting requester is granted within NREQ grants.
- Requester obligation: hold valid, op and operands stable until accepted. The block does not check this.

## Timing
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, busy=0, ptr=0, state=EMPTY, req_ready=0.
- Latency: acceptance in cycle N gives rsp_valid=1 with the result in cycle N+1.
- Throughput: 1 result per cycle while rsp_ready=1.
- Reset asserted mid-operation: the held result is discarded immediately (asynchronous) and ptr returns to 0. First grant after release goes to the lowest-index valid requester.
- Simultaneous drain and request in FULL: the old result is consumed and the new result is loaded on the same edge. rsp_valid stays 1.

## Structure
- Package logic_op_pkg holds the opcode constants (OP_XOR=2'd0, OP_XNOR=2'd1, OP_NAND=2'd2, OP_NOR=2'd3) and the function clog2.
- Sub-module logic_op_unit: purely combinational (op, a, b) -> y, WIDTH-parameterised, instanced once after the grant mux.
- Top level contains the round-robin pointer, the grant priority search, the operand mux, the 2-state FSM and the output register.

## Test plan
- Requester 0 only: XOR, a=8'hF0, b=8'hAA -> next cycle rsp_valid=1, rsp_y=8'h5A, rsp_id=0.
- Requester 1, a=8'hC3, b=8'h0F, ops 0..3 back-to-back with rsp_ready=1 -> results 8'hCC, 8'h33, 8'hFC, 8'h30 on consecutive cycles.
- All 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one grant per cycle.
- Backpressure: rsp_ready=0 for 5 cycles while all requesters are valid -> rsp_y and rsp_id stable, req_ready=0. Then rsp_ready=1 -> drain and next grant on the same edge.
- Wrap: grant requester 3, then only 0 and 3 valid -> requester 0 granted first, then 3.
- Assert rst_n low while FULL with rsp_ready=0 -> rsp_valid=0 immediately. After release with 2 and 3 valid -> requester 2 granted first.
